// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch-stage program counter: FSM encoding and
// the default reset/trap vectors used when the sequencer is instantiated
// without overrides.
package cpu_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } pc_state_e;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;
  localparam int unsigned INSTR_BYTES  = 32'd4;

endpackage

// File: rtl/pc_redirect_buffer.sv
// Holds a branch target that arrived while fetch was stalled, so it can be
// applied on the first unstalled advance. Latest capture wins; capture has
// priority over clear. Nothing changes unless advance is high.
module pc_redirect_buffer #(
  parameter int unsigned NrOfBits = 32
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                advance,
  input  logic                capture,
  input  logic                clear,
  input  logic [NrOfBits-1:0] target,
  output logic                valid,
  output logic [NrOfBits-1:0] pending_target
);

  logic                valid_r;
  logic [NrOfBits-1:0] target_r;

  // Pending-target register: capture on stalled branch, drop when consumed.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      valid_r  <= 1'b0;
      target_r <= {NrOfBits{1'b0}};
    end else if (advance && capture) begin
      valid_r  <= 1'b1;
      target_r <= target;
    end else if (advance && clear) begin
      valid_r  <= 1'b0;
    end
  end

  assign valid          = valid_r;
  assign pending_target = target_r;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter for the RV32 fetch stage: reset vector, sequential
// increment, branch redirect, trap entry/return with saved EPC, halt/resume
// and buffering of redirects that arrive while fetch is stalled.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned          NrOfBits    = 32,
  parameter logic [NrOfBits-1:0]  ResetVector = NrOfBits'(RESET_VECTOR),
  parameter logic [NrOfBits-1:0]  TrapVector  = NrOfBits'(TRAP_VECTOR),
  parameter int unsigned          InstrBytes  = INSTR_BYTES
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ClockEnable,
  input  logic                Tick,
  input  logic                Stall,
  input  logic                BranchTaken,
  input  logic [NrOfBits-1:0] BranchTarget,
  input  logic                TrapReq,
  input  logic                TrapRet,
  input  logic                Halt,
  input  logic                Resume,
  output logic [NrOfBits-1:0] PC,
  output logic [NrOfBits-1:0] EPC,
  output logic                Halted,
  output logic                RedirectPending
);

  logic [NrOfBits-1:0] pc_r;
  logic [NrOfBits-1:0] epc_r;
  pc_state_e           state_r;

  logic [NrOfBits-1:0] pc_next_s;
  logic [NrOfBits-1:0] epc_next_s;
  pc_state_e           state_next_s;
  logic [NrOfBits-1:0] pc_inc_s;
  logic [NrOfBits-1:0] branch_aligned_s;
  logic [NrOfBits-1:0] pend_target_s;
  logic                pend_valid_s;
  logic                advance_s;
  logic                capture_s;
  logic                clear_s;

  assign advance_s        = ClockEnable & Tick;
  // Low two bits are dropped; misaligned targets are trapped upstream.
  assign branch_aligned_s = BranchTarget & ~NrOfBits'(2'b11);
  assign pc_inc_s         = pc_r + NrOfBits'(InstrBytes);

  pc_redirect_buffer #(
    .NrOfBits (NrOfBits)
  ) u_redirect_buffer (
    .Clock          (Clock),
    .Reset          (Reset),
    .advance        (advance_s),
    .capture        (capture_s),
    .clear          (clear_s),
    .target         (branch_aligned_s),
    .valid          (pend_valid_s),
    .pending_target (pend_target_s)
  );

  // Next-PC priority mux and RUN/HALTED transitions for one advance cycle.
  always_comb begin
    pc_next_s    = pc_r;
    epc_next_s   = epc_r;
    state_next_s = state_r;
    capture_s    = 1'b0;
    clear_s      = 1'b0;
    if (advance_s) begin
      case (state_r)
        ST_RUN: begin
          if (TrapReq) begin
            pc_next_s  = TrapVector;
            epc_next_s = pc_r;
            clear_s    = 1'b1;
          end else if (Stall) begin
            capture_s  = BranchTaken;
          end else if (TrapRet) begin
            pc_next_s  = epc_r;
            clear_s    = 1'b1;
          end else if (BranchTaken) begin
            pc_next_s  = branch_aligned_s;
            clear_s    = 1'b1;
          end else if (pend_valid_s) begin
            pc_next_s  = pend_target_s;
            clear_s    = 1'b1;
          end else if (Halt) begin
            pc_next_s    = pc_inc_s;
            state_next_s = ST_HALTED;
          end else begin
            pc_next_s  = pc_inc_s;
          end
        end
        ST_HALTED: begin
          if (TrapReq) begin
            pc_next_s    = TrapVector;
            epc_next_s   = pc_r;
            state_next_s = ST_RUN;
            clear_s      = 1'b1;
          end else if (Resume) begin
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_HALTED;
          end
        end
        default: begin
          state_next_s = ST_RUN;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Architectural PC/EPC/state registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_r    <= ResetVector;
      epc_r   <= {NrOfBits{1'b0}};
      state_r <= ST_RUN;
    end else begin
      pc_r    <= pc_next_s;
      epc_r   <= epc_next_s;
      state_r <= state_next_s;
    end
  end

  assign PC              = pc_r;
  assign EPC             = epc_r;
  assign Halted          = (state_r == ST_HALTED);
  assign RedirectPending = pend_valid_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes the reference model's
// expected post-edge state, a monitor pops and compares on each falling edge.
module tb_pc_sequencer;

  logic        Clock = 1'b0;
  logic        Reset, ClockEnable, Tick, Stall, BranchTaken;
  logic [31:0] BranchTarget;
  logic        TrapReq, TrapRet, Halt, Resume;
  logic [31:0] PC, EPC;
  logic        Halted, RedirectPending;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        halted;
    logic        pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state (abstract, spec-level).
  logic [31:0] m_pc, m_epc, m_pt;
  logic        m_halted, m_pend;

  pc_sequencer dut (
    .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
    .Stall(Stall), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .TrapReq(TrapReq), .TrapRet(TrapRet), .Halt(Halt), .Resume(Resume),
    .PC(PC), .EPC(EPC), .Halted(Halted), .RedirectPending(RedirectPending)
  );

  always #5 Clock = ~Clock;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endfunction

  // Apply the spec rules to the model for one rising edge.
  task automatic model_edge();
    logic [31:0] al;
    al = BranchTarget & 32'hFFFF_FFFC;
    if (Reset) begin
      m_pc = 32'h0; m_epc = 32'h0; m_halted = 1'b0; m_pend = 1'b0; m_pt = 32'h0;
    end else if (ClockEnable && Tick) begin
      if (m_halted) begin
        if (TrapReq) begin
          m_epc = m_pc; m_pc = 32'h100; m_halted = 1'b0; m_pend = 1'b0;
        end else if (Resume) m_halted = 1'b0;
      end else if (TrapReq) begin
        m_epc = m_pc; m_pc = 32'h100; m_pend = 1'b0;
      end else if (Stall) begin
        if (BranchTaken) begin m_pt = al; m_pend = 1'b1; end
      end else if (TrapRet) begin
        m_pc = m_epc; m_pend = 1'b0;
      end else if (BranchTaken) begin
        m_pc = al; m_pend = 1'b0;
      end else if (m_pend) begin
        m_pc = m_pt; m_pend = 1'b0;
      end else begin
        m_pc = m_pc + 32'd4;
        if (Halt) m_halted = 1'b1;
      end
    end
  endtask

  // Drive one cycle (called at a falling edge), model the edge, queue expectation.
  task automatic step(input logic rst, input logic ce, input logic tk,
                      input logic st, input logic br, input logic [31:0] bt,
                      input logic tq, input logic trt, input logic hl,
                      input logic rs);
    Reset = rst; ClockEnable = ce; Tick = tk; Stall = st; BranchTaken = br;
    BranchTarget = bt; TrapReq = tq; TrapRet = trt; Halt = hl; Resume = rs;
    @(posedge Clock);
    model_edge();
    exp_q.push_back('{pc: m_pc, epc: m_epc, halted: m_halted, pend: m_pend});
    @(negedge Clock);
  endtask

  task automatic adv();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic branch(input logic [31:0] t);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, t, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: the DUT presents its state every cycle; compare against queue.
  always @(negedge Clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc", PC, e.pc);
      chk("epc", EPC, e.epc);
      chk("halted", {31'd0, Halted}, {31'd0, e.halted});
      chk("redirect_pending", {31'd0, RedirectPending}, {31'd0, e.pend});
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; ClockEnable = 1'b0; Tick = 1'b0; Stall = 1'b0;
    BranchTaken = 1'b0; BranchTarget = 32'h0; TrapReq = 1'b0; TrapRet = 1'b0;
    Halt = 1'b0; Resume = 1'b0;
    m_pc = 32'h0; m_epc = 32'h0; m_pt = 32'h0; m_halted = 1'b0; m_pend = 1'b0;
    @(negedge Clock);

    // Reset, increments, Tick=0 hold, reset with ClockEnable=0.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_pc", PC, 32'h0);
    adv(); adv(); adv();
    chk("inc3_pc", PC, 32'h00C);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tick0_hold", PC, 32'h00C);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_ce0", PC, 32'h0);

    // Stalled redirects: latest wins, applied after stall drops.
    branch(32'h010);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h203, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall_hold", PC, 32'h010);
    chk("pending_set", {31'd0, RedirectPending}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 1'b0);
    adv();
    chk("pending_apply", PC, 32'h300);

    // Trap entry while stalled, return, simultaneous trap/return.
    branch(32'h040);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("trap_epc", EPC, 32'h040);
    adv(); adv(); adv();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("trapret_pc", PC, 32'h040);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("trap_and_ret_pc", PC, 32'h100);

    // Halt, ignored branches, resume.
    branch(32'h080);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("halt_pc", PC, 32'h084);
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("halted_nocapture", {31'd0, RedirectPending}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    adv();
    chk("resume_inc", PC, 32'h088);

    // Trap out of HALTED.
    branch(32'h080);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("halted_trap_epc", EPC, 32'h084);

    // Wrap-around and reset discarding a pending redirect.
    branch(32'hFFFF_FFFC);
    adv();
    chk("wrap_pc", PC, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h700, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_drops_pending", {31'd0, RedirectPending}, 32'd0);
    adv();

    // Randomised traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0,
           $urandom,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0);
    end

    @(negedge Clock);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
